fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC register, drives the instruction-memory request, and contains the IF/ID pipeline register. Consumes `holdPC`/`holdIF_ID` from the hazard detection unit and the resolved branch redirect, and feeds the decode stage with instruction, PC+4 and a valid bit. A one-entry skid buffer absorbs an instruction returned while IF/ID is held, so no memory response is lost.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 15 +
 rtl/fetch_stage_if_id_reg.sv | 46 ++++
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_e - fetch FSM states (BOOT, FETCH, STALL)
//   fetch_word_t  - one fetched instruction together with its PC+4
//   DEF_RESET_PC / DEF_NOP_INSTR - default reset PC and bubble encoding
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_word_t;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus.
//   imem_req   - fetch request valid (fetch side drives)
//   imem_addr  - word-aligned fetch address (fetch side drives)
//   imem_ready - imem_rdata is valid this cycle for the current request
//   imem_rdata - fetched instruction
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   flush  - clear to {NOP_INSTR, 0, invalid}; beats every other control
//   hold   - keep current contents
//   load   - capture dataIn as a valid instruction
//   none   - insert a bubble: NOP_INSTR, pc4 kept, invalid
//   instr/pc4/valid - register contents fed to decode
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  fetch_word_t dataIn,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (hold) begin
      instr <= instr;
    end else if (load) begin
      instr <= dataIn.instr;
      pc4   <= dataIn.pc4;
      valid <= 1'b1;
    end else begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the five-stage MIPS pipeline.
// Owns the PC, drives the instruction-memory request and contains the IF/ID
// register plus a one-entry skid buffer that catches a word returned while
// IF/ID is held.
//   clk, rst_n             - clock, async active-low reset
//   holdPC, holdIF_ID      - hazard-unit freezes
//   branch_taken/_target   - one-cycle redirect, target low bits masked
//   imem (master)          - instruction-memory bus
//   if_id_instr/pc4/valid  - IF/ID contents to decode
//   align_err              - sticky misaligned-target flag
// Optional: define FETCH_ALIGN_CHECK_EN to enable the misaligned-target check;
// without it align_err is constant 0.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               holdPC,
  input  logic               holdIF_ID,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  fetch_stage_if.master      imem,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic               align_err
);

  localparam logic [1:0] stBoot  = BOOT;
  localparam logic [1:0] stFetch = FETCH;
  localparam logic [1:0] stStall = STALL;

  logic [1:0]  state;
  logic [31:0] pc;
  fetch_word_t skid;

  logic [31:0] pcPlus4;
  logic [31:0] redirectPc;
  logic        redirect;
  fetch_word_t fetched;

  assign pcPlus4    = pc + 32'd4;  // wraps modulo 2^32
  assign redirectPc = {branch_target[31:2], 2'b00};
  assign redirect   = branch_taken && (state != stBoot);
  assign fetched    = '{instr: imem.imem_rdata, pc4: pcPlus4};

  // Request depends on registered state only; no input reaches the bus.
  assign imem.imem_req  = (state == stFetch);
  assign imem.imem_addr = pc;

  // The skid is full exactly when in STALL, so leaving STALL (release or
  // redirect) empties it without touching the data bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= stBoot;
      pc    <= RESET_PC;
      skid  <= '0;
    end else if (redirect) begin
      pc    <= redirectPc;
      state <= stFetch;
    end else begin
      case (state)
        stBoot:  state <= stFetch;
        stFetch: begin
          if (imem.imem_ready) begin
            if (!holdPC) pc <= pcPlus4;
            if (holdIF_ID) begin
              skid  <= fetched;
              state <= stStall;
            end
          end
        end
        stStall: if (!holdIF_ID) state <= stFetch;
        default: state <= stBoot;
      endcase
    end
  end

  logic        ifHold;
  logic        ifLoad;
  fetch_word_t ifData;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ifHold = 1'b1;
    ifLoad = 1'b0;
    ifData = fetched;
    case (state)
      stFetch: begin
        ifHold = holdIF_ID;
        ifLoad = imem.imem_ready;  // not ready and not held -> bubble
      end
      stStall: begin
        ifHold = holdIF_ID;
        ifLoad = 1'b1;
        ifData = skid;
      end
      default: ;
    endcase
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifIdReg (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (redirect),
    .hold   (ifHold),
    .load   (ifLoad),
    .dataIn (ifData),
    .instr  (if_id_instr),
    .pc4    (if_id_pc4),
    .valid  (if_id_valid)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic alignErrQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      alignErrQ <= 1'b0;
    else if (redirect && (branch_target[1:0] != 2'b00))
      alignErrQ <= 1'b1;
  end

  assign align_err = alignErrQ;
`else
  logic unusedTargetLsbs;
  assign unusedTargetLsbs = ^branch_target[1:0];
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// Memory model returns rdata = address, ready under bench control.
module tb_fetch_stage;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        holdPC;
  logic        holdIfId;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        ready;
  logic [31:0] ifIdInstr;
  logic [31:0] ifIdPc4;
  logic        ifIdValid;
  logic        alignErr;

  int checks   = 0;
  int failures = 0;

  fetch_stage_if bus ();
  assign bus.imem_ready = ready;
  assign bus.imem_rdata = bus.imem_addr;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .holdPC        (holdPC),
    .holdIF_ID     (holdIfId),
    .branch_taken  (branchTaken),
    .branch_target (branchTarget),
    .imem          (bus),
    .if_id_instr   (ifIdInstr),
    .if_id_pc4     (ifIdPc4),
    .if_id_valid   (ifIdValid),
    .align_err     (alignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIfId(input string tag, input logic [31:0] instr,
                           input logic [31:0] pc4, input logic valid);
    check({tag, ".instr"}, ifIdInstr, instr);
    check({tag, ".pc4"}, ifIdPc4, pc4);
    check({tag, ".valid"}, {31'd0, ifIdValid}, {31'd0, valid});
  endtask

  task automatic checkBus(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".req"}, {31'd0, bus.imem_req}, {31'd0, req});
    check({tag, ".addr"}, bus.imem_addr, addr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b1; holdPC = 1'b0; holdIfId = 1'b0;
    branchTaken = 1'b0; branchTarget = '0;
    repeat (2) tick();

    // Reset state
    checkBus("reset", 1'b0, 32'h0);
    checkIfId("reset", 32'h0, 32'h0, 1'b0);
    check("reset.align", {31'd0, alignErr}, 32'd0);

    // BOOT -> FETCH, then one instruction per cycle
    rst_n = 1'b1;
    tick();
    checkBus("boot", 1'b1, 32'h0);
    check("boot.valid", {31'd0, ifIdValid}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkIfId($sformatf("stream%0d", i), 32'(4 * (i - 1)), 32'(4 * i), 1'b1);
      checkBus($sformatf("stream%0d", i), 1'b1, 32'(4 * i));
    end

    // Word at 0x10 captured in skid while IF/ID held
    holdIfId = 1'b1;
    tick();
    checkIfId("skidcap", 32'h0C, 32'h10, 1'b1);
    checkBus("skidcap", 1'b0, 32'h14);
    holdPC = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkIfId($sformatf("stall%0d", i), 32'h0C, 32'h10, 1'b1);
      checkBus($sformatf("stall%0d", i), 1'b0, 32'h14);
    end
    holdIfId = 1'b0; holdPC = 1'b0;
    tick();
    checkIfId("release", 32'h10, 32'h14, 1'b1);
    checkBus("release", 1'b1, 32'h14);
    tick();
    checkIfId("postrel", 32'h14, 32'h18, 1'b1);
    checkBus("postrel", 1'b1, 32'h18);

    // holdPC alone: IF/ID loads, PC frozen, same word refetched
    holdPC = 1'b1;
    tick();
    checkIfId("holdpc", 32'h18, 32'h1C, 1'b1);
    checkBus("holdpc", 1'b1, 32'h18);
    holdPC = 1'b0;
    tick();
    checkIfId("refetch", 32'h18, 32'h1C, 1'b1);
    checkBus("refetch", 1'b1, 32'h1C);

    // Branch while IF/ID held and skid full
    holdIfId = 1'b1;
    tick();
    checkBus("prebr", 1'b0, 32'h20);
    branchTaken = 1'b1; branchTarget = 32'h400;
    tick();
    checkIfId("brflush", 32'h0, 32'h0, 1'b0);
    checkBus("brflush", 1'b1, 32'h400);
    branchTaken = 1'b0; holdIfId = 1'b0;
    tick();
    checkIfId("brtarget", 32'h400, 32'h404, 1'b1);
    checkBus("brtarget", 1'b1, 32'h404);

    // Memory not ready for two cycles: bubbles, PC constant
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkIfId($sformatf("bubble%0d", i), 32'h0, 32'h404, 1'b0);
      checkBus($sformatf("bubble%0d", i), 1'b1, 32'h404);
    end
    ready = 1'b1;
    tick();
    checkIfId("resume", 32'h404, 32'h408, 1'b1);
    checkBus("resume", 1'b1, 32'h408);

    // Not ready and held: nothing changes
    ready = 1'b0; holdIfId = 1'b1;
    tick();
    checkIfId("nrhold", 32'h404, 32'h408, 1'b1);
    checkBus("nrhold", 1'b1, 32'h408);
    ready = 1'b1; holdIfId = 1'b0;

    // PC wrap at the top of the address space
    branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFC;
    tick();
    checkBus("wrapbr", 1'b1, 32'hFFFF_FFFC);
    branchTaken = 1'b0;
    tick();
    checkIfId("wrap", 32'hFFFF_FFFC, 32'h0, 1'b1);
    checkBus("wrap", 1'b1, 32'h0);

    // Misaligned target: masked, flag depends on build
    branchTaken = 1'b1; branchTarget = 32'h402;
    tick();
    checkBus("misal", 1'b1, 32'h400);
    check("misal.align", {31'd0, alignErr}, {31'd0, ALIGN_EN});
    branchTaken = 1'b0;
    tick();
    checkIfId("misal2", 32'h400, 32'h404, 1'b1);
    check("misal2.align", {31'd0, alignErr}, {31'd0, ALIGN_EN});

    // Asynchronous reset mid-request
    rst_n = 1'b0;
    #1;
    checkBus("areset", 1'b0, 32'h0);
    checkIfId("areset", 32'h0, 32'h0, 1'b0);
    check("areset.align", {31'd0, alignErr}, 32'd0);
    tick();

    // Branch during BOOT is ignored (no redirect, no align flag)
    branchTaken = 1'b1; branchTarget = 32'h802;
    rst_n = 1'b1;
    tick();
    checkBus("bootbr", 1'b1, 32'h0);
    check("bootbr.align", {31'd0, alignErr}, 32'd0);
    branchTaken = 1'b0;
    tick();
    checkIfId("bootbr2", 32'h0, 32'h4, 1'b1);
    checkBus("bootbr2", 1'b1, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
